// File: rtl/window_gen_3x3_pkg.sv
// Shared Q8.24 constants and the 3x3 tap layout used by the window generator and the neuron stage.
package window_gen_3x3_pkg;

  localparam int Q_WIDTH = 32;
  localparam int Q_FBITS = 24;
  localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0100_0000;

  // Taps are row-major: index 0 is a_1 (oldest row, oldest column), index 8 is a_9.
  localparam int TAP_DIM    = 3;
  localparam int N_TAPS     = TAP_DIM * TAP_DIM;
  localparam int TAP_CENTRE = 4;

  function automatic int tap_idx(input int r, input int c);
    return r * TAP_DIM + c;
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of storage: single-port circular RAM, combinational read of the old word,
// write of the new word on the same address when enabled.
module window_gen_3x3_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Contents are never emitted before being rewritten, so no reset is needed.
  always_ff @(posedge clk) begin
    if (en) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator with two internal line buffers and one output register stage.
// Define WINDOW_GEN_POS_EN to add win_row/win_col (centre-pixel coordinate of the emitted window).
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] pix_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] a_1,
  output logic signed [WIDTH-1:0] a_2,
  output logic signed [WIDTH-1:0] a_3,
  output logic signed [WIDTH-1:0] a_4,
  output logic signed [WIDTH-1:0] a_5,
  output logic signed [WIDTH-1:0] a_6,
  output logic signed [WIDTH-1:0] a_7,
  output logic signed [WIDTH-1:0] a_8,
  output logic signed [WIDTH-1:0] a_9,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done
`ifdef WINDOW_GEN_POS_EN
  ,
  output logic [RW-1:0]           win_row,
  output logic [CW-1:0]           win_col
`endif
);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIDTH-1:0] win_q [N_TAPS];
  logic [WIDTH-1:0] win_d [N_TAPS];
  logic [WIDTH-1:0] tap_q [N_TAPS];
  logic [WIDTH-1:0] tap_d [N_TAPS];
  logic [WIDTH-1:0] new_col [TAP_DIM];
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [WIDTH-1:0] lb0_rd, lb1_rd;
  logic             accept, emit, col_last, row_last;
`ifdef WINDOW_GEN_POS_EN
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is fed lb0's old word as lb0 is overwritten.
  window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH), .AW(CW)) lb0 (
    .clk(clk), .en(accept), .addr(col_q), .wdata(pix_in), .rdata(lb0_rd)
  );
  window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH), .AW(CW)) lb1 (
    .clk(clk), .en(accept), .addr(col_q), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    tap_d        = tap_q;
    out_valid_d  = out_valid_q;
    frame_done_d = accept && col_last && row_last;
    new_col[0]   = lb1_rd;
    new_col[1]   = lb0_rd;
    new_col[2]   = pix_in;
`ifdef WINDOW_GEN_POS_EN
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
`endif
    if (accept) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
      for (int r = 0; r < TAP_DIM; r++) begin
        for (int c = 0; c < TAP_DIM - 1; c++) win_d[tap_idx(r, c)] = win_q[tap_idx(r, c + 1)];
        win_d[tap_idx(r, TAP_DIM - 1)] = new_col[r];
      end
    end
    if (emit) begin
      tap_d       = win_d;
      out_valid_d = 1'b1;
`ifdef WINDOW_GEN_POS_EN
      win_row_d   = row_q - RW'(1);
      win_col_d   = col_q - CW'(1);
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        win_q[i] <= '0;
        tap_q[i] <= '0;
      end
`ifdef WINDOW_GEN_POS_EN
      win_row_q    <= '0;
      win_col_q    <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      tap_q        <= tap_d;
`ifdef WINDOW_GEN_POS_EN
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign a_1 = tap_q[tap_idx(0, 0)];
  assign a_2 = tap_q[tap_idx(0, 1)];
  assign a_3 = tap_q[tap_idx(0, 2)];
  assign a_4 = tap_q[tap_idx(1, 0)];
  assign a_5 = tap_q[TAP_CENTRE];
  assign a_6 = tap_q[tap_idx(1, 2)];
  assign a_7 = tap_q[tap_idx(2, 0)];
  assign a_8 = tap_q[tap_idx(2, 1)];
  assign a_9 = tap_q[tap_idx(2, 2)];
`ifdef WINDOW_GEN_POS_EN
  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed and randomised bench for window_gen_3x3 on a 5x4 image; covers the position outputs
// when WINDOW_GEN_POS_EN is defined.
module tb_window_gen_3x3;
  import window_gen_3x3_pkg::*;

  localparam int W  = Q_WIDTH;
  localparam int IW = 5;
  localparam int IH = 4;

  typedef logic [9*W-1:0] win_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pix_in = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, frame_done;
  logic [W-1:0] a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9;
`ifdef WINDOW_GEN_POS_EN
  logic [1:0]   win_row;
  logic [2:0]   win_col;
`endif

  window_gen_3x3 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .in_valid(in_valid), .in_ready(in_ready),
    .a_1(a_1), .a_2(a_2), .a_3(a_3), .a_4(a_4), .a_5(a_5), .a_6(a_6), .a_7(a_7), .a_8(a_8), .a_9(a_9),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
`ifdef WINDOW_GEN_POS_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fd_cnt   = 0;
  win_t got_q[$];
  int   got_cyc[$];
  logic [4:0] got_pos[$];
  logic s_acc, s_ov, s_ir;
  win_t s_taps;
  int   acc_cyc [40];
  logic ov_at   [40];

  function automatic win_t cur_taps();
    return {a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9};
  endfunction

  function automatic logic [4:0] cur_pos();
`ifdef WINDOW_GEN_POS_EN
    return {win_row, win_col};
`else
    return 5'd0;
`endif
  endfunction

  function automatic win_t pk(input int v0, input int v1, input int v2, input int v3, input int v4,
                              input int v5, input int v6, input int v7, input int v8, input bit neg);
    int v[9];
    logic [W-1:0] p;
    win_t w;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    w = '0;
    for (int i = 0; i < 9; i++) begin
      p = W'(v[i]) << Q_FBITS;
      if (neg) p = -p;
      w[(8-i)*W +: W] = p;
    end
    return w;
  endfunction

  // Windows of the k-ramp frame in emission order; s is the pixel index at a_1.
  function automatic win_t exp_win(input int i, input bit neg);
    int s[6];
    int b;
    s = '{0, 1, 2, 5, 6, 7};
    b = s[i];
    return pk(b, b+1, b+2, b+5, b+6, b+7, b+10, b+11, b+12, neg);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] pix, input logic ordy);
    @(negedge clk);
    in_valid = v; pix_in = pix; out_ready = ordy;
    #1;
    s_acc  = v && in_ready;
    s_ov   = out_valid;
    s_ir   = in_ready;
    s_taps = cur_taps();
    if (out_valid && ordy) begin
      got_q.push_back(s_taps);
      got_cyc.push_back(cyc);
      got_pos.push_back(cur_pos());
    end
    if (frame_done) fd_cnt++;
    cyc++;
  endtask

  task automatic clear_log();
    got_q.delete(); got_cyc.delete(); got_pos.delete();
    fd_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send(input int k, input bit neg, input logic ordy, input int idx);
    logic [W-1:0] p;
    int tries;
    p = W'(k) * Q_ONE;
    if (neg) p = -p;
    tries = 0;
    do begin
      step(1'b1, p, ordy);
      tries++;
    end while (!s_acc && tries < 50);
    if (!s_acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted, in_ready=%b, required acceptance within 50 cycles", k, s_ir);
    end
    acc_cyc[idx] = cyc - 1;
    ov_at[idx]   = s_ov;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (cur_taps() !== '0) begin n_fail++; $display("FAIL reset_taps: got %h want 0", cur_taps()); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef WINDOW_GEN_POS_EN
    n_checks++; if (cur_pos() !== 5'd0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", cur_pos()); end
`endif
  endtask

  task automatic test_single_frame();
    apply_reset();
    for (int k = 0; k < 20; k++) send(k, 1'b0, 1'b1, k);
    drain(3);
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL frame_window_count: got %0d want 6", got_q.size()); end
    n_checks++; if (got_q[0] !== pk(0,1,2,5,6,7,10,11,12,0)) begin n_fail++; $display("FAIL first_window: got %h want %h", got_q[0], pk(0,1,2,5,6,7,10,11,12,0)); end
    n_checks++; if (got_cyc[0] !== acc_cyc[12] + 1) begin n_fail++; $display("FAIL first_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[12] + 1); end
    n_checks++; if (got_q[3] !== pk(5,6,7,10,11,12,15,16,17,0)) begin n_fail++; $display("FAIL row_edge_window: got %h want %h", got_q[3], pk(5,6,7,10,11,12,15,16,17,0)); end
    n_checks++; if (got_q[5] !== pk(7,8,9,12,13,14,17,18,19,0)) begin n_fail++; $display("FAIL last_window: got %h want %h", got_q[5], pk(7,8,9,12,13,14,17,18,19,0)); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (got_q[i] !== exp_win(i, 1'b0)) begin n_fail++; $display("FAIL frame_window_%0d: got %h want %h", i, got_q[i], exp_win(i, 1'b0)); end
    end
    n_checks++; if (ov_at[13] !== 1'b1) begin n_fail++; $display("FAIL ov_after_k12: got %b want 1", ov_at[13]); end
    n_checks++; if (ov_at[16] !== 1'b0) begin n_fail++; $display("FAIL row_edge_ov_k15: got %b want 0", ov_at[16]); end
    n_checks++; if (ov_at[17] !== 1'b0) begin n_fail++; $display("FAIL row_edge_ov_k16: got %b want 0", ov_at[17]); end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] p13;
    apply_reset();
    for (int k = 0; k < 13; k++) send(k, 1'b0, 1'b1, k);
    p13 = W'(13) * Q_ONE;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, p13, 1'b0);
      n_checks++; if (s_ir !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d: got %b want 0", i, s_ir); end
      n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid_%0d: got %b want 1", i, s_ov); end
      n_checks++; if (s_taps !== exp_win(0, 1'b0)) begin n_fail++; $display("FAIL stall_taps_%0d: got %h want %h", i, s_taps, exp_win(0, 1'b0)); end
    end
    for (int k = 13; k < 20; k++) send(k, 1'b0, 1'b1, k);
    drain(3);
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL stall_window_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (got_q[i] !== exp_win(i, 1'b0)) begin n_fail++; $display("FAIL stall_window_%0d: got %h want %h", i, got_q[i], exp_win(i, 1'b0)); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL stall_frame_done: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 20; k++) send(k, 1'b0, 1'b1, k);
    for (int k = 0; k < 20; k++) send(k, 1'b1, 1'b1, 20 + k);
    drain(3);
    n_checks++; if (got_q.size() !== 12) begin n_fail++; $display("FAIL b2b_window_count: got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (got_q[i] !== exp_win(i % 6, i >= 6)) begin n_fail++; $display("FAIL b2b_window_%0d: got %h want %h", i, got_q[i], exp_win(i % 6, i >= 6)); end
    end
    n_checks++; if (acc_cyc[20] !== acc_cyc[19] + 1) begin n_fail++; $display("FAIL b2b_gap: got cycle %0d want %0d", acc_cyc[20], acc_cyc[19] + 1); end
    n_checks++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    for (int k = 0; k < 10; k++) send(k, 1'b0, 1'b1, k);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_k9_flags: got ov=%b fd=%b want 0/0", out_valid, frame_done); end
    n_checks++; if (cur_taps() !== '0) begin n_fail++; $display("FAIL midrst_k9_taps: got %h want 0", cur_taps()); end
    apply_reset();
    for (int k = 0; k < 13; k++) send(k, 1'b0, 1'b0, k);
    step(1'b0, '0, 1'b0);
    n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got %b want 1", s_ov); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_ov: got %b want 0", out_valid); end
    n_checks++; if (cur_taps() !== '0) begin n_fail++; $display("FAIL midrst_async_taps: got %h want 0", cur_taps()); end
    apply_reset();
    for (int k = 0; k < 20; k++) send(k, 1'b0, 1'b1, k);
    drain(3);
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL midrst_window_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (got_q[i] !== exp_win(i, 1'b0)) begin n_fail++; $display("FAIL midrst_window_%0d: got %h want %h", i, got_q[i], exp_win(i, 1'b0)); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL midrst_frame_done: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_random();
    logic [W-1:0] img [IH][IW];
    win_t exp_q[$];
    logic [4:0] exp_pos[$];
    int mr, mc, nmis, nwin;
    win_t g, e, w;
    logic [4:0] gp, ep;
    logic [W-1:0] p;
    apply_reset();
    mr = 0; mc = 0; nmis = 0; nwin = 0;
    for (int n = 0; n < 1300; n++) begin
      if (n < 1200) step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 9) < 7);
      else step(1'b0, '0, 1'b1);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        gp = got_pos.pop_front();
        void'(got_cyc.pop_front());
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; nmis++;
          $display("FAIL rand_extra_window: got %h with no window expected", g);
        end else begin
          e = exp_q.pop_front();
          ep = exp_pos.pop_front();
          nwin++;
          n_checks++; if (g !== e) begin n_fail++; nmis++; $display("FAIL rand_window_%0d: got %h want %h", nwin, g, e); end
`ifdef WINDOW_GEN_POS_EN
          n_checks++; if (gp !== ep) begin n_fail++; nmis++; $display("FAIL rand_pos_%0d: got %h want %h", nwin, gp, ep); end
`endif
        end
      end
      if (s_acc) begin
        p = pix_in;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
          w = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[(8 - (i*3 + j))*W +: W] = img[mr-2+i][mc-2+j];
          exp_q.push_back(w);
          exp_pos.push_back({2'(mr - 1), 3'(mc - 1)});
        end
        if (mc == IW - 1) begin
          mc = 0;
          mr = (mr == IH - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_dropped: got %0d windows outstanding want 0", exp_q.size()); end
    n_checks++; if (nwin < 50) begin n_fail++; $display("FAIL rand_window_total: got %0d windows want at least 50", nwin); end
    n_checks++; if (nmis !== 0) begin n_fail++; $display("FAIL rand_mismatches: got %0d want 0", nmis); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 sliding-window generator. Sits directly upstream of the 9-input neuron and drives its a_1..a_9 operands.
- Accepts a raster-order pixel stream in Q8.24 fixed point and buffers two image lines internally.
- Emits one full 3x3 window per accepted pixel once the window is valid ("valid" padding only, no borders).
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, pixel/tap word width (Q8.24, signed).
- IMG_W, 8, image width in pixels (>=3).
- IMG_H, 8, image height in pixels (>=3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  WIDTH  signed input pixel.
- in_valid  in  1  pix_in valid.
- in_ready  out  1  block can accept pix_in this cycle.
- a_1..a_9  out  WIDTH each  window taps, row-major; a_1 = pixel(r-2,c-2), a_5 = pixel(r-1,c-1), a_9 = pixel(r,c).
- out_valid  out  1  taps valid.
- out_ready  in  1  downstream consumes taps.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Handshakes:
  - Accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register stage).
  - Output transfer = out_valid && out_ready.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1; both advance only on accept.
  - col wraps to 0 and row increments at col = IMG_W-1.
  - At row = IMG_H-1 and col = IMG_W-1, both wrap to 0 and frame_done pulses on the next cycle.
- Line buffers:
  - Two circular buffers of IMG_W words, addressed by col.
  - On accept: lb1[col] <= lb0[col]; lb0[col] <= pix_in.
  - Column taps read before the write: {lb1[col], lb0[col], pix_in} = rows r-2, r-1, r.
- Window register:
  - 3x3 array shifts left one column on each accept; the new column enters on the right (a_3/a_6/a_9).
  - The shift also happens for col < 2 and row < 2; those shifts produce no output.
- Output:
  - On an accept with row >= 2 && col >= 2, the taps are registered and out_valid is set next cycle. Latency is 1 cycle.
  - out_valid clears on transfer unless a new window is loaded in the same cycle.
  - Taps hold stable while out_valid && !out_ready.
- Window count: (IMG_W-2)*(IMG_H-2) windows per frame. Frames run back-to-back with no gap cycles; line buffers are reused without clearing, since stale data is never emitted.
- Reset, asynchronous:
  - out_valid = 0, frame_done = 0.
  - a_1..a_9 = 0, col = row = 0.
  - in_ready = 1 on the first cycle after release.
  - Line buffer contents are don't-care and need no reset.
- Reset mid-frame aborts the frame; the next accepted pixel is treated as (0,0).
- Simultaneous output transfer and new window in one cycle: the new window loads and out_valid stays 1.
- in_valid low: all state holds.
- Arithmetic: pure data movement; no width change and no saturation.

Optional Feature:
- Macro: WINDOW_GEN_POS_EN.
- With the macro defined:
  - Adds outputs win_row and win_col, each $clog2(IMG_H) / $clog2(IMG_W) bits wide.
  - They carry the centre-pixel coordinate (r-1, c-1), registered alongside the taps with the same reset value 0 and the same hold rules.
- Without the macro, the ports do not exist and there is no extra logic.

Decomposition:
- Shared package/include (Util/q_format.vh) holds:
  - Q-format constants: WIDTH = 32, FBITS = 24, Q_ONE = 32'h0100_0000.
  - A tap-index layout constant shared with the neuron stage.
- One natural sub-module: line_buffer, a single-port read-before-write circular RAM of depth IMG_W × WIDTH with enable.
  - Instantiated twice: lb0 and lb1.

Test Plan:
- IMG_W=5, IMG_H=4; stream pixel k = k<<24 for k=0..19, out_ready=1 →
  - Exactly 6 windows.
  - First window appears the cycle after k=12 is accepted, with taps {0,1,2,5,6,7,10,11,12}<<24.
  - Last window taps {7,8,9,12,13,14,17,18,19}<<24.
  - frame_done pulses once.
- Row edge: accepts at col 0 and 1 of rows >= 2 (k=15,16) → no out_valid. Next window, after k=17, is {5,6,7,10,11,12,15,16,17}<<24.
- Backpressure: hold out_ready=0 for 4 cycles with a window pending →
  - in_ready=0.
  - Taps and out_valid stable.
  - No pixel lost; the sequence matches the no-stall run.
- Back-to-back frames: two frames, the second using pixel -(k<<24) → 12 windows total; the second frame's first window is the negated first-window values; two frame_done pulses.
- Reset mid-frame: assert rst after k=9 →
  - Outputs go to 0 immediately.
  - After release, a restarted 20-pixel frame yields exactly 6 correct windows.
- Random in_valid/out_ready gaps (≥1000 cycles) against a reference model → zero mismatches, no duplicated or dropped windows; with WINDOW_GEN_POS_EN, win_row/win_col match the model.
